// File: rtl/cmd_serial_to_parallel_if.sv
// CMD-line response receiver bus: controller-side enable/config, CMD pad input,
// received frame and status flags, plus the receiver's FSM state for observation.
interface cmd_serial_to_parallel_if;
  logic         enable_stp_wrapper;
  logic         long_response;
  logic         cmd_pin_in;
  logic [135:0] pad_response;
  logic         reception_complete;
  logic         start_timeout;
  logic         frame_error;
  logic         crc_error;
  logic [2:0]   fsm_state;

  modport master (
    output enable_stp_wrapper, long_response, cmd_pin_in,
    input  pad_response, reception_complete, start_timeout, frame_error, crc_error, fsm_state
  );

  modport slave (
    input  enable_stp_wrapper, long_response, cmd_pin_in,
    output pad_response, reception_complete, start_timeout, frame_error, crc_error, fsm_state
  );
endinterface

// File: rtl/cmd_serial_to_parallel.sv
// SD host CMD-line response receiver: hunts for the start bit, shifts in a 48/136-bit frame.
// Optional CRC7 checking is compiled in when CMD_CRC7_CHECK_EN is defined.
module cmd_serial_to_parallel #(
  parameter int SHORT_LEN = 48,
  parameter int LONG_LEN  = 136,
  parameter int NCR_MAX   = 64,
  parameter int CNT_W     = 8
) (
  input logic sd_clock,
  input logic reset,
  cmd_serial_to_parallel_if.slave bus
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_WAIT    = 3'd1;
  localparam logic [2:0] ST_SHIFT   = 3'd2;
  localparam logic [2:0] ST_DONE    = 3'd3;
  localparam logic [2:0] ST_TIMEOUT = 3'd4;

  // Handshake: enable_stp_wrapper is a level request. While high the receiver runs
  // one reception and then holds its result (reception_complete or start_timeout);
  // dropping it aborts or acknowledges, returning to IDLE on the next sd_clock edge.
  logic [2:0]          state;
  logic [CNT_W-1:0]    cnt;
  logic [LONG_LEN-1:0] sr;
  logic                len_sel;
  logic [LONG_LEN-1:0] pad_q;
  logic                rc_q;
  logic                to_q;
  logic                fe_q;
  logic [CNT_W-1:0]    last_idx;
  logic [LONG_LEN-1:0] frame_aligned;

  assign last_idx = len_sel ? CNT_W'(LONG_LEN - 1) : CNT_W'(SHORT_LEN - 1);
  assign frame_aligned = len_sel ? sr
                                 : {{(LONG_LEN - SHORT_LEN){1'b0}}, sr[SHORT_LEN-1:0]};

  always_ff @(posedge sd_clock) begin
    if (reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      sr      <= '0;
      len_sel <= 1'b0;
      pad_q   <= '0;
      rc_q    <= 1'b0;
      to_q    <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          cnt  <= '0;
          sr   <= '0;
          rc_q <= 1'b0;
          to_q <= 1'b0;
          fe_q <= 1'b0;
          if (bus.enable_stp_wrapper) begin
            len_sel <= bus.long_response;
            state   <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (!bus.enable_stp_wrapper) begin
            state <= ST_IDLE;
          end else if (!bus.cmd_pin_in) begin
            // cnt doubles as the bit index: the start bit is bit 0
            sr    <= {sr[LONG_LEN-2:0], 1'b0};
            cnt   <= CNT_W'(1);
            state <= ST_SHIFT;
          end else if (cnt == CNT_W'(NCR_MAX - 1)) begin
            to_q  <= 1'b1;
            state <= ST_TIMEOUT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_SHIFT: begin
          if (!bus.enable_stp_wrapper) begin
            state <= ST_IDLE;
          end else begin
            sr  <= {sr[LONG_LEN-2:0], bus.cmd_pin_in};
            cnt <= cnt + 1'b1;
            if (cnt == last_idx) state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (!bus.enable_stp_wrapper) begin
            rc_q  <= 1'b0;
            fe_q  <= 1'b0;
            state <= ST_IDLE;
          end else if (!rc_q) begin
            pad_q <= frame_aligned;
            rc_q  <= 1'b1;
            fe_q  <= ~sr[0];
          end
        end
        ST_TIMEOUT: begin
          if (!bus.enable_stp_wrapper) begin
            to_q  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef CMD_CRC7_CHECK_EN
  logic [6:0] crc;
  logic [6:0] crc_next;
  logic       crc_en;
  logic       crc_err_q;

  // CRC7 x^7+x^3+1; covers everything before the CRC field, except the long
  // frame's leading 8 bits (start, transmission, reserved).
  always_comb begin
    crc_next = {crc[5:0], 1'b0} ^ ({7{bus.cmd_pin_in ^ crc[6]}} & 7'h09);
    crc_en   = len_sel ? (cnt >= CNT_W'(8) && cnt <= CNT_W'(LONG_LEN - 9))
                       : (cnt <= CNT_W'(SHORT_LEN - 9));
  end

  always_ff @(posedge sd_clock) begin
    if (reset) begin
      crc       <= '0;
      crc_err_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          crc       <= '0;
          crc_err_q <= 1'b0;
        end
        ST_WAIT:  crc <= '0;
        ST_SHIFT: if (bus.enable_stp_wrapper && crc_en) crc <= crc_next;
        ST_DONE: begin
          if (!bus.enable_stp_wrapper) crc_err_q <= 1'b0;
          else if (!rc_q)              crc_err_q <= (crc != sr[7:1]);
        end
        default: crc_err_q <= crc_err_q;
      endcase
    end
  end

  assign bus.crc_error = crc_err_q;
`else
  assign bus.crc_error = 1'b0;
`endif

  assign bus.pad_response       = pad_q;
  assign bus.reception_complete = rc_q;
  assign bus.start_timeout      = to_q;
  assign bus.frame_error        = fe_q;
  assign bus.fsm_state          = state;

endmodule

// File: tb/tb_cmd_serial_to_parallel.sv
// Bench for cmd_serial_to_parallel: table of response frames plus hand-written
// timeout, abort and mid-frame reset sequences.
module tb_cmd_serial_to_parallel;
  localparam int SHORT_LEN = 48;
  localparam int LONG_LEN  = 136;
  localparam int NCR_MAX   = 64;

  logic sd_clock = 1'b0;
  logic reset;
  always #5 sd_clock = ~sd_clock;

  cmd_serial_to_parallel_if bus ();
  cmd_serial_to_parallel dut (
    .sd_clock (sd_clock),
    .reset    (reset),
    .bus      (bus)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  always @(posedge sd_clock) cyc <= cyc + 1;

  typedef struct {
    logic         long_r;
    logic [135:0] frame;
    int           idle;
    logic         exp_fe;
  } vec_t;

  vec_t         vecs[5];
  logic [135:0] exp_q[$];
  logic [1:0]   exp_flag_q[$];
  logic [135:0] last_pad;

  task automatic check(input string name, input logic [135:0] act, input logic [135:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] crc7_model(input logic [135:0] f, input logic long_r);
    logic [6:0] c;
    logic       fb;
    int         hi;
    c  = 7'd0;
    hi = long_r ? 127 : 47;
    for (int i = hi; i >= 8; i--) begin
      fb = f[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  function automatic logic exp_crc_err(input logic [135:0] f, input logic long_r);
`ifdef CMD_CRC7_CHECK_EN
    return crc7_model(f, long_r) != f[7:1];
`else
    return 1'b0;
`endif
  endfunction

  task automatic check_idle_flags(input string tag);
    check({tag, "_rc_clr"}, 136'(bus.reception_complete), 136'(0));
    check({tag, "_to_clr"}, 136'(bus.start_timeout), 136'(0));
    check({tag, "_fe_clr"}, 136'(bus.frame_error), 136'(0));
    check({tag, "_crc_clr"}, 136'(bus.crc_error), 136'(0));
    check({tag, "_state_idle"}, 136'(bus.fsm_state), 136'(0));
  endtask

  task automatic send_frame(input vec_t v, input string tag);
    int           len;
    int           c0;
    int           k;
    logic [135:0] exp_pad;
    logic [1:0]   exp_flags;
    len = v.long_r ? LONG_LEN : SHORT_LEN;
    c0  = 0;
    @(negedge sd_clock);
    bus.enable_stp_wrapper = 1'b1;
    bus.long_response      = v.long_r;
    bus.cmd_pin_in         = 1'b1;
    repeat (v.idle) @(negedge sd_clock);
    for (int i = len - 1; i >= 0; i--) begin
      @(negedge sd_clock);
      bus.cmd_pin_in = v.frame[i];
      if (i == len - 1) begin
        c0 = cyc;
        exp_pad = v.long_r ? v.frame : {88'd0, v.frame[47:0]};
        exp_q.push_back(exp_pad);
        exp_flag_q.push_back({v.exp_fe, exp_crc_err(v.frame, v.long_r)});
      end
    end
    @(negedge sd_clock);
    bus.cmd_pin_in = 1'b1;
    k = 0;
    while (!bus.reception_complete && k < 8) begin
      @(negedge sd_clock);
      k++;
    end
    exp_pad   = exp_q.pop_front();
    exp_flags = exp_flag_q.pop_front();
    if (!bus.reception_complete) begin
      check({tag, "_rc_wait"}, 136'(bus.reception_complete), 136'(1));
    end else begin
      check({tag, "_latency"}, 136'(cyc - c0 - 1), 136'(len));
      check({tag, "_pad"}, bus.pad_response, exp_pad);
      check({tag, "_fe"}, 136'(bus.frame_error), 136'(exp_flags[1]));
      check({tag, "_crc"}, 136'(bus.crc_error), 136'(exp_flags[0]));
      check({tag, "_to_excl"}, 136'(bus.start_timeout), 136'(0));
      last_pad = exp_pad;
    end
    bus.enable_stp_wrapper = 1'b0;
    @(negedge sd_clock);
    check_idle_flags(tag);
    check({tag, "_pad_held"}, bus.pad_response, last_pad);
  endtask

  initial begin
    logic [37:0] rnd;
    int          c0;
    int          k;

    reset                  = 1'b1;
    bus.enable_stp_wrapper = 1'b0;
    bus.long_response      = 1'b0;
    bus.cmd_pin_in         = 1'b1;
    last_pad               = '0;
    repeat (3) @(negedge sd_clock);
    reset = 1'b0;
    @(negedge sd_clock);
    check("reset_pad", bus.pad_response, 136'(0));
    check_idle_flags("reset");

    vecs[0] = '{long_r: 1'b0, frame: 136'h40_0000_0000_95, idle: 5, exp_fe: 1'b0};
    vecs[1] = '{long_r: 1'b0, frame: 136'h40_0000_0000_94, idle: 2, exp_fe: 1'b1};
    vecs[2] = '{long_r: 1'b0, frame: 136'h40_0000_0000_97, idle: 0, exp_fe: 1'b0};
    vecs[3].long_r = 1'b1;
    vecs[3].frame  = {8'h3F, 120'h0123_4567_89AB_CDEF_0011_2233_4455_66, 7'd0, 1'b1};
    vecs[3].frame[7:1] = crc7_model(vecs[3].frame, 1'b1);
    vecs[3].idle   = 7;
    vecs[3].exp_fe = 1'b0;
    rnd = 38'($urandom) ^ (38'($urandom) << 6);
    vecs[4].long_r = 1'b0;
    vecs[4].frame  = {88'd0, 2'b01, rnd, 7'd0, 1'b1};
    vecs[4].frame[7:1] = crc7_model(vecs[4].frame, 1'b0);
    vecs[4].idle   = $urandom_range(1, 20);
    vecs[4].exp_fe = 1'b0;

    for (int i = 0; i < 5; i++) send_frame(vecs[i], $sformatf("vec%0d", i));

    // no start bit: timeout after NCR_MAX cycles in WAIT_START
    @(negedge sd_clock);
    bus.enable_stp_wrapper = 1'b1;
    bus.long_response      = 1'b0;
    bus.cmd_pin_in         = 1'b1;
    c0 = cyc;
    k  = 0;
    while (!bus.start_timeout && k < 100) begin
      @(negedge sd_clock);
      k++;
    end
    check("timeout_seen", 136'(bus.start_timeout), 136'(1));
    check("timeout_cycles", 136'(cyc - c0 - 1), 136'(NCR_MAX));
    check("timeout_rc_excl", 136'(bus.reception_complete), 136'(0));
    check("timeout_pad_held", bus.pad_response, last_pad);
    bus.enable_stp_wrapper = 1'b0;
    @(negedge sd_clock);
    check_idle_flags("timeout");

    // abort mid-frame, then a clean frame
    @(negedge sd_clock);
    bus.enable_stp_wrapper = 1'b1;
    repeat (3) @(negedge sd_clock);
    for (int i = 47; i >= 27; i--) begin
      bus.cmd_pin_in = vecs[2].frame[i];
      @(negedge sd_clock);
    end
    bus.enable_stp_wrapper = 1'b0;
    bus.cmd_pin_in         = 1'b1;
    @(negedge sd_clock);
    check_idle_flags("abort");
    check("abort_pad_held", bus.pad_response, last_pad);
    repeat (3) @(negedge sd_clock);
    check("abort_no_rc", 136'(bus.reception_complete), 136'(0));
    send_frame(vecs[0], "after_abort");

    // reset mid-SHIFT clears everything
    @(negedge sd_clock);
    bus.enable_stp_wrapper = 1'b1;
    repeat (2) @(negedge sd_clock);
    for (int i = 47; i >= 37; i--) begin
      bus.cmd_pin_in = vecs[0].frame[i];
      @(negedge sd_clock);
    end
    reset = 1'b1;
    @(negedge sd_clock);
    check("midreset_pad", bus.pad_response, 136'(0));
    check_idle_flags("midreset");
    reset                  = 1'b0;
    bus.enable_stp_wrapper = 1'b0;
    bus.cmd_pin_in         = 1'b1;
    @(negedge sd_clock);
    check("scoreboard_empty", 136'(exp_q.size()), 136'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench time limit reached");
  end
endmodule
